// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port arbiter in front of the SQI SRAM interface. Port A (audio datapath)
// normally has priority. Port B (host registers) is guaranteed a grant after
// STARVE_LIMIT consecutive A grants made while B was waiting. Each grant runs
// one memory transaction and returns a one-cycle ack to the winning port. A
// watchdog aborts a transaction whose mem_ack never arrives. In that case the
// port gets all-ones read data, its ack, and a sticky timeout_err.
//
// Ports
//   clk          system clock; all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request, held until a_ack
//   a_rdata/a_ack               port A read data / one-cycle completion
//   b_req/b_we/b_addr/b_wdata   port B request, held until b_ack
//   b_rdata/b_ack               port B read data / one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata   request towards the SRAM interface
//   mem_rdata/mem_ack                   response from the SRAM interface
//   timeout_err  sticky watchdog flag
//   clr_err      clears timeout_err; a timeout in the same cycle wins
//
// States
//   state | meaning
//   IDLE  | no transaction; arbitrate among requests
//   BUSY  | mem_req high, waiting for mem_ack or watchdog expiry
//   DONE  | one cycle; ack of the granted port high
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,

    output logic              timeout_err,
    input  logic              clr_err
);

    // The streak counter is at least 3 bits wide and always wide enough to
    // reach STARVE_LIMIT.
    localparam int STREAK_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam int TMO_W    = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    // The watchdog is a down-counter. It is loaded at the grant and expires on
    // the TIMEOUT-th BUSY cycle, which is the cycle where it reads zero.
    localparam logic [TMO_W-1:0]    TMO_LOAD   = TMO_W'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_LIMIT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic                grant_b, grant_b_next;
    logic [STREAK_W-1:0] a_streak, a_streak_next;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_next;

    logic                mem_req_next;
    logic                mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_next;
    logic [DATA_W-1:0]   a_rdata_next;
    logic [DATA_W-1:0]   b_rdata_next;
    logic                a_ack_next;
    logic                b_ack_next;
    logic                err_next;

    logic                pick_b;
    logic                finish;
    logic                load_rdata;
    logic [DATA_W-1:0]   resp_data;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        grant_b_next   = grant_b;
        a_streak_next  = a_streak;
        tmo_cnt_next   = tmo_cnt;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        a_rdata_next   = a_rdata;
        b_rdata_next   = b_rdata;
        a_ack_next     = 1'b0;
        b_ack_next     = 1'b0;
        err_next       = timeout_err;
        pick_b         = 1'b0;
        finish         = 1'b0;
        load_rdata     = 1'b0;
        resp_data      = mem_rdata;

        // Clear first so that a timeout later in this block overrides it.
        if (clr_err) begin
            err_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    pick_b = b_req && (!a_req || (a_streak == STREAK_LIM));

                    if (pick_b || !b_req) begin
                        a_streak_next = '0;
                    end else if (a_streak != STREAK_MAX) begin
                        a_streak_next = a_streak + 1'b1;
                    end

                    grant_b_next   = pick_b;
                    mem_req_next   = 1'b1;
                    mem_we_next    = pick_b ? b_we    : a_we;
                    mem_addr_next  = pick_b ? b_addr  : a_addr;
                    mem_wdata_next = pick_b ? b_wdata : a_wdata;
                    tmo_cnt_next   = TMO_LOAD;
                    state_next     = BUSY;
                end
            end

            BUSY: begin
                if (mem_ack) begin
                    // A completion in the watchdog's final cycle still counts
                    // as normal completion.
                    finish     = 1'b1;
                    load_rdata = !mem_we;
                    resp_data  = mem_rdata;
                end else if (tmo_cnt == '0) begin
                    // An aborted transaction returns all-ones, even for writes.
                    finish     = 1'b1;
                    load_rdata = 1'b1;
                    resp_data  = '1;
                    err_next   = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt - 1'b1;
                end

                if (finish) begin
                    mem_req_next = 1'b0;
                    tmo_cnt_next = '0;
                    state_next   = DONE;
                    if (grant_b) begin
                        b_ack_next = 1'b1;
                        if (load_rdata) begin
                            b_rdata_next = resp_data;
                        end
                    end else begin
                        a_ack_next = 1'b1;
                        if (load_rdata) begin
                            a_rdata_next = resp_data;
                        end
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_b     <= 1'b0;
            a_streak    <= '0;
            tmo_cnt     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            grant_b     <= grant_b_next;
            a_streak    <= a_streak_next;
            tmo_cnt     <= tmo_cnt_next;
            mem_req     <= mem_req_next;
            mem_we      <= mem_we_next;
            mem_addr    <= mem_addr_next;
            mem_wdata   <= mem_wdata_next;
            a_rdata     <= a_rdata_next;
            b_rdata     <= b_rdata_next;
            a_ack       <= a_ack_next;
            b_ack       <= b_ack_next;
            timeout_err <= err_next;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, a_we, b_req, b_we;
    logic [16:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [15:0] a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic        mem_req, mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        timeout_err, clr_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(17), .DATA_W(16), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    typedef struct {
        logic        a_req;
        logic        b_req;
        logic        a_we;
        logic [16:0] a_addr;
        logic [15:0] a_wdata;
        logic        b_we;
        logic [16:0] b_addr;
        logic [15:0] b_wdata;
        int          lat;
        logic [15:0] rdata;
        logic        exp_b;
        logic [15:0] exp_a_rdata;
        logic [15:0] exp_b_rdata;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Waits on negedges for mem_req. n is the number of negedges it took.
    task automatic wait_req(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Called at the first negedge with mem_req high. Returns at the negedge
    // after the mem_ack cycle, when the DUT should be in DONE.
    task automatic respond(input int lat, input logic [15:0] d);
        repeat (lat - 1) @(negedge clk);
        chk("req_held", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    vec_t        v;
    bit          ok;
    int          n;
    int          cnt;
    logic [9:0]  exp_seq;
    logic        got_b;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        mem_rdata = 16'hDEAD; mem_ack = 0; clr_err = 0;

        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acks", {a_ack, b_ack}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_err", timeout_err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{1'b1, 1'b0, 1'b0, 17'h00010, 16'h0000, 1'b0, 17'h00000, 16'h0000, 3, 16'h1234, 1'b0, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 17'h00000, 16'h0000, 1'b1, 17'h1FFFF, 16'hBEEF, 1, 16'h5555, 1'b1, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 17'h00000, 16'h0000, 1'b0, 17'h00100, 16'h0000, 2, 16'hCAFE, 1'b1, 16'h1234, 16'hCAFE};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 17'h00020, 16'h1111, 1'b0, 17'h00200, 16'h0000, 1, 16'h7777, 1'b0, 16'h1234, 16'hCAFE};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 17'h0ABCD, 16'h0000, 1'b0, 17'h00000, 16'h0000, 4, 16'h0F0F, 1'b0, 16'h0F0F, 16'hCAFE};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 17'h00000, 16'h0000, 1'b0, 17'h00000, 16'h0000, 1, 16'hFFFE, 1'b0, 16'hFFFE, 16'hCAFE};

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
            b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
            wait_req(ok, n);
            chk("vec_grant_seen", ok, 1);
            chk("vec_grant_latency", n, 1);
            chk("vec_mem_addr", mem_addr, v.exp_b ? v.b_addr : v.a_addr);
            chk("vec_mem_we", mem_we, v.exp_b ? v.b_we : v.a_we);
            chk("vec_mem_wdata", mem_wdata, v.exp_b ? v.b_wdata : v.a_wdata);
            respond(v.lat, v.rdata);
            chk("vec_a_ack", a_ack, !v.exp_b);
            chk("vec_b_ack", b_ack, v.exp_b);
            chk("vec_a_rdata", a_rdata, v.exp_a_rdata);
            chk("vec_b_rdata", b_rdata, v.exp_b_rdata);
            chk("vec_mem_req_drop", mem_req, 0);
            a_req = 0; b_req = 0;
            @(negedge clk);
            chk("vec_ack_single", {a_ack, b_ack}, 0);
            @(negedge clk);
        end

        // Both ports requesting continuously: B wins every fifth grant.
        exp_seq = 10'b10000_10000;
        a_req = 1; a_we = 0; a_addr = 17'h00001;
        b_req = 1; b_we = 0; b_addr = 17'h00002;
        for (int i = 0; i < 10; i++) begin
            wait_req(ok, n);
            chk("starve_grant_seen", ok, 1);
            chk("starve_gap", n, (i == 0) ? 1 : 2);
            got_b = (mem_addr == 17'h00002);
            chk("starve_order", got_b, exp_seq[i]);
            respond(1, 16'h1000 + 16'(i));
            chk("starve_b_ack", b_ack, exp_seq[i]);
            chk("starve_a_ack", a_ack, !exp_seq[i]);
        end
        a_req = 0; b_req = 0;
        chk("starve_a_rdata", a_rdata, 16'h1008);
        chk("starve_b_rdata", b_rdata, 16'h1009);
        repeat (2) @(negedge clk);

        // mem_ack withheld: the watchdog aborts after 255 cycles of mem_req.
        a_req = 1; a_we = 0; a_addr = 17'h00030;
        wait_req(ok, n);
        chk("tmo_grant_seen", ok, 1);
        cnt = 0;
        while (mem_req && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_cycles", cnt, 255);
        chk("tmo_a_ack", a_ack, 1);
        chk("tmo_b_ack", b_ack, 0);
        chk("tmo_a_rdata", a_rdata, 16'hFFFF);
        chk("tmo_err_set", timeout_err, 1);
        a_req = 0;
        @(negedge clk);
        chk("tmo_err_sticky", timeout_err, 1);
        chk("tmo_ack_single", a_ack, 0);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("tmo_err_clear", timeout_err, 0);
        @(negedge clk);

        // mem_ack in the watchdog's last cycle counts as normal completion.
        a_req = 1; a_addr = 17'h00031;
        wait_req(ok, n);
        chk("tmo_edge_grant_seen", ok, 1);
        cnt = 0;
        while (mem_req && cnt < 254) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_edge_req_high", mem_req, 1);
        mem_ack = 1; mem_rdata = 16'h4321;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 16'hDEAD;
        chk("tmo_edge_ack", a_ack, 1);
        chk("tmo_edge_rdata", a_rdata, 16'h4321);
        chk("tmo_edge_no_err", timeout_err, 0);
        a_req = 0;
        repeat (2) @(negedge clk);

        // A timeout that coincides with clr_err still leaves the flag set.
        clr_err = 1;
        a_req = 1; a_addr = 17'h00032;
        wait_req(ok, n);
        cnt = 0;
        while (mem_req && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_clr_cycles", cnt, 255);
        chk("tmo_clr_err_wins", timeout_err, 1);
        chk("tmo_clr_ack", a_ack, 1);
        clr_err = 0; a_req = 0;
        @(negedge clk);
        chk("tmo_clr_err_held", timeout_err, 1);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("tmo_clr_err_cleared", timeout_err, 0);

        // mem_ack while idle is ignored.
        mem_ack = 1; mem_rdata = 16'h9999;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 16'hDEAD;
        chk("idle_ack_no_ack", {a_ack, b_ack}, 0);
        chk("idle_ack_no_req", mem_req, 0);
        @(negedge clk);
        chk("idle_ack_still_no_ack", {a_ack, b_ack}, 0);
        chk("idle_ack_a_rdata", a_rdata, 16'hFFFF);

        // Reset in the middle of BUSY abandons the transaction.
        a_req = 1; a_we = 0; a_addr = 17'h00040;
        wait_req(ok, n);
        chk("rstmid_grant_seen", ok, 1);
        repeat (2) @(negedge clk);
        reset_n = 0;
        #1;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_a_rdata", a_rdata, 0);
        chk("rstmid_acks", {a_ack, b_ack}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_acks_held", {a_ack, b_ack}, 0);
        chk("rstmid_mem_req_held", mem_req, 0);
        reset_n = 1;
        wait_req(ok, n);
        chk("rstmid_regrant_seen", ok, 1);
        chk("rstmid_regrant_addr", mem_addr, 17'h00040);
        respond(2, 16'h2468);
        chk("rstmid_a_ack", a_ack, 1);
        chk("rstmid_a_rdata_new", a_rdata, 16'h2468);
        a_req = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
